conv_mac_pipe: RTL and testbench

Pipelined, parametrised KxK convolution MAC. It is the successor to the fixed box-blur MAC and slots in after the line-buffer/window generator. It adds signed, runtime-programmable coefficients with a shadow/active bank, a programmable rounding right-shift, unsigned or absolute-value output modes with saturation, and a full valid/ready handshake at one window per cycle.

---
 rtl/conv_pkg.sv | 41 ++++
 rtl/conv_coef_bank.sv | 95 +++++++++
 rtl/conv_mac_pipe.sv | 190 +++++++++++++++++++
 tb/tb_conv_mac_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : conv_pkg
// Brief    : Shared constants and width helpers for the KxK convolution MAC.
// Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

   localparam logic MODE_CLIP = 1'b0;
   localparam logic MODE_ABS  = 1'b1;

   // Ceiling log2; returns 0 for values <= 1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   // Signed product width of a zero-extended pixel times a signed coefficient.
   function automatic int prod_width(input int dw, input int cw);
      return dw + cw + 1;
   endfunction

   // Accumulator width large enough that summing every tap cannot overflow.
   function automatic int acc_width(input int dw, input int cw, input int taps);
      return prod_width(dw, cw) + clog2(taps);
   endfunction

   // Identity kernel: centre tap is 1, all other taps are 0.
   function automatic int identity_coef(input int tap, input int taps);
      return (tap == taps / 2) ? 1 : 0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/conv_coef_bank.sv
`default_nettype none
// ============================================================================
// Module   : conv_coef_bank
// Brief    : Shadow/active register banks for coefficients, shift and mode.
//            Writes land in the shadow bank; commit copies shadow to active.
// Revision : 1.0 - initial release
// ============================================================================
module conv_coef_bank
   import conv_pkg::*;
#(
   parameter int NTAPS       = 9,
   parameter int COEF_WIDTH  = 8,
   parameter int SHIFT_WIDTH = 4,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        coef_wr_en,
   input  logic [ADDR_WIDTH-1:0]       coef_addr,
   input  logic [COEF_WIDTH-1:0]       coef_wdata,
   input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
   input  logic                        cfg_mode,
   input  logic                        cfg_wr_en,
   input  logic                        cfg_commit,
   output logic [NTAPS*COEF_WIDTH-1:0] act_coefs,
   output logic [SHIFT_WIDTH-1:0]      act_shift,
   output logic                        act_mode
);

   logic [COEF_WIDTH-1:0]  shd_coef_q [NTAPS];
   logic [COEF_WIDTH-1:0]  shd_coef_d [NTAPS];
   logic [COEF_WIDTH-1:0]  act_coef_q [NTAPS];
   logic [COEF_WIDTH-1:0]  act_coef_d [NTAPS];
   logic [SHIFT_WIDTH-1:0] shd_shift_q, shd_shift_d, act_shift_q, act_shift_d;
   logic                   shd_mode_q, shd_mode_d, act_mode_q, act_mode_d;

   // Commit copies the pre-write shadow contents; writes to out-of-range taps match nothing.
   always_comb begin
      shd_shift_d = shd_shift_q;
      shd_mode_d  = shd_mode_q;
      act_shift_d = act_shift_q;
      act_mode_d  = act_mode_q;
      if (cfg_commit) begin
         act_shift_d = shd_shift_q;
         act_mode_d  = shd_mode_q;
      end
      if (cfg_wr_en) begin
         shd_shift_d = cfg_shift;
         shd_mode_d  = cfg_mode;
      end
      for (int t = 0; t < NTAPS; t++) begin
         shd_coef_d[t] = shd_coef_q[t];
         act_coef_d[t] = act_coef_q[t];
         if (cfg_commit) begin
            act_coef_d[t] = shd_coef_q[t];
         end
         if (coef_wr_en && (int'(coef_addr) == t)) begin
            shd_coef_d[t] = coef_wdata;
         end
      end
   end

   // Both banks reset to the identity kernel with shift 0 and clip mode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shd_shift_q <= '0;
         shd_mode_q  <= MODE_CLIP;
         act_shift_q <= '0;
         act_mode_q  <= MODE_CLIP;
         for (int t = 0; t < NTAPS; t++) begin
            shd_coef_q[t] <= COEF_WIDTH'(identity_coef(t, NTAPS));
            act_coef_q[t] <= COEF_WIDTH'(identity_coef(t, NTAPS));
         end
      end else begin
         shd_shift_q <= shd_shift_d;
         shd_mode_q  <= shd_mode_d;
         act_shift_q <= act_shift_d;
         act_mode_q  <= act_mode_d;
         for (int t = 0; t < NTAPS; t++) begin
            shd_coef_q[t] <= shd_coef_d[t];
            act_coef_q[t] <= act_coef_d[t];
         end
      end
   end

   // Flatten with tap 0 in the MSBs to match the window ordering.
   for (genvar t = 0; t < NTAPS; t++) begin : g_flat
      assign act_coefs[(NTAPS-1-t)*COEF_WIDTH +: COEF_WIDTH] = act_coef_q[t];
   end

   assign act_shift = act_shift_q;
   assign act_mode  = act_mode_q;

endmodule
`default_nettype wire

// File: rtl/conv_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : conv_mac_pipe
// Brief    : Three-stage pipelined KxK convolution MAC with programmable signed
//            coefficients, rounding shift, clip/abs modes and saturation.
// Revision : 1.0 - initial release
// ============================================================================
module conv_mac_pipe
   import conv_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int KERNEL_SIZE = 3,
   parameter int COEF_WIDTH  = 8,
   parameter int SHIFT_WIDTH = 4
) (
   input  logic                                             clk,
   input  logic                                             rst_n,
   input  logic                                             in_valid,
   output logic                                             in_ready,
   input  logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0]    data_in,
   input  logic                                             coef_wr_en,
   input  logic [clog2(KERNEL_SIZE*KERNEL_SIZE)-1:0]        coef_addr,
   input  logic [COEF_WIDTH-1:0]                            coef_wdata,
   input  logic [SHIFT_WIDTH-1:0]                           cfg_shift,
   input  logic                                             cfg_mode,
   input  logic                                             cfg_wr_en,
   input  logic                                             cfg_commit,
   output logic                                             out_valid,
   input  logic                                             out_ready,
   output logic [DATA_WIDTH-1:0]                            mac_out,
   output logic                                             out_sat
);

   localparam int NTAPS      = KERNEL_SIZE * KERNEL_SIZE;
   localparam int ADDR_WIDTH = clog2(NTAPS);
   localparam int PROD_W     = prod_width(DATA_WIDTH, COEF_WIDTH);
   localparam int ACC_W      = acc_width(DATA_WIDTH, COEF_WIDTH, NTAPS);
   localparam logic signed [ACC_W:0] c_one = {{ACC_W{1'b0}}, 1'b1};
   localparam logic signed [ACC_W:0] c_max = {{(ACC_W+1-DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

   logic [NTAPS*COEF_WIDTH-1:0] act_coefs;
   logic [SHIFT_WIDTH-1:0]      act_shift;
   logic                        act_mode;

   conv_coef_bank #(
      .NTAPS       (NTAPS),
      .COEF_WIDTH  (COEF_WIDTH),
      .SHIFT_WIDTH (SHIFT_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH)
   ) u_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .coef_wr_en (coef_wr_en),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .cfg_shift  (cfg_shift),
      .cfg_mode   (cfg_mode),
      .cfg_wr_en  (cfg_wr_en),
      .cfg_commit (cfg_commit),
      .act_coefs  (act_coefs),
      .act_shift  (act_shift),
      .act_mode   (act_mode)
   );

   logic                     en;
   logic signed [PROD_W-1:0] pix_ext  [NTAPS];
   logic signed [PROD_W-1:0] coef_ext [NTAPS];

   logic                     v1_q, v1_d, v2_q, v2_d;
   logic signed [PROD_W-1:0] prod1_q [NTAPS];
   logic signed [PROD_W-1:0] prod1_d [NTAPS];
   logic [SHIFT_WIDTH-1:0]   shift1_q, shift1_d, shift2_q, shift2_d;
   logic                     mode1_q, mode1_d, mode2_q, mode2_d;
   logic signed [ACC_W-1:0]  sum2_q, sum2_d;
   logic                     out_valid_q, out_valid_d, out_sat_q, out_sat_d;
   logic [DATA_WIDTH-1:0]    mac_out_q, mac_out_d;
   logic signed [ACC_W:0]    rnd_sum, res;

   // A single global enable freezes every stage while the output is back-pressured.
   assign en       = !out_valid_q || out_ready;
   assign in_ready = en;

   for (genvar t = 0; t < NTAPS; t++) begin : g_tap
      assign pix_ext[t]  = {{(PROD_W-DATA_WIDTH){1'b0}}, data_in[(NTAPS-1-t)*DATA_WIDTH +: DATA_WIDTH]};
      assign coef_ext[t] = {{(PROD_W-COEF_WIDTH){act_coefs[(NTAPS-1-t)*COEF_WIDTH + COEF_WIDTH-1]}},
                            act_coefs[(NTAPS-1-t)*COEF_WIDTH +: COEF_WIDTH]};
   end

   // Stage 1: per-tap products with the active bank; shift/mode travel with the window.
   always_comb begin
      v1_d     = v1_q;
      shift1_d = shift1_q;
      mode1_d  = mode1_q;
      for (int t = 0; t < NTAPS; t++) begin
         prod1_d[t] = prod1_q[t];
      end
      if (en) begin
         v1_d     = in_valid;
         shift1_d = act_shift;
         mode1_d  = act_mode;
         for (int t = 0; t < NTAPS; t++) begin
            prod1_d[t] = pix_ext[t] * coef_ext[t];
         end
      end
   end

   // Stage 2: signed sum of all products, sign-extended to the accumulator width.
   always_comb begin
      v2_d     = v2_q;
      shift2_d = shift2_q;
      mode2_d  = mode2_q;
      sum2_d   = sum2_q;
      if (en) begin
         v2_d     = v1_q;
         shift2_d = shift1_q;
         mode2_d  = mode1_q;
         sum2_d   = '0;
         for (int t = 0; t < NTAPS; t++) begin
            sum2_d = sum2_d + {{(ACC_W-PROD_W){prod1_q[t][PROD_W-1]}}, prod1_q[t]};
         end
      end
   end

   // Stage 3: round-half-up arithmetic shift, optional absolute value, then saturate.
   always_comb begin
      rnd_sum = {sum2_q[ACC_W-1], sum2_q};
      if (shift2_q != '0) begin
         rnd_sum = rnd_sum + (c_one << (shift2_q - SHIFT_WIDTH'(1)));
      end
      res = rnd_sum >>> shift2_q;
      if ((mode2_q == MODE_ABS) && (res < 0)) begin
         res = -res;
      end
      out_valid_d = out_valid_q;
      mac_out_d   = mac_out_q;
      out_sat_d   = out_sat_q;
      if (en) begin
         out_valid_d = v2_q;
         if (res < 0) begin
            mac_out_d = '0;
            out_sat_d = 1'b1;
         end else if (res > c_max) begin
            mac_out_d = {DATA_WIDTH{1'b1}};
            out_sat_d = 1'b1;
         end else begin
            mac_out_d = res[DATA_WIDTH-1:0];
            out_sat_d = 1'b0;
         end
      end
   end

   // Pipeline registers; reset discards all in-flight windows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         shift1_q    <= '0;
         shift2_q    <= '0;
         mode1_q     <= MODE_CLIP;
         mode2_q     <= MODE_CLIP;
         sum2_q      <= '0;
         out_valid_q <= 1'b0;
         mac_out_q   <= '0;
         out_sat_q   <= 1'b0;
         for (int t = 0; t < NTAPS; t++) begin
            prod1_q[t] <= '0;
         end
      end else begin
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         shift1_q    <= shift1_d;
         shift2_q    <= shift2_d;
         mode1_q     <= mode1_d;
         mode2_q     <= mode2_d;
         sum2_q      <= sum2_d;
         out_valid_q <= out_valid_d;
         mac_out_q   <= mac_out_d;
         out_sat_q   <= out_sat_d;
         for (int t = 0; t < NTAPS; t++) begin
            prod1_q[t] <= prod1_d[t];
         end
      end
   end

   assign out_valid = out_valid_q;
   assign mac_out   = mac_out_q;
   assign out_sat   = out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_mac_pipe
// Brief    : Self-checking bench for conv_mac_pipe (K=3, 8-bit data/coefs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_mac_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [71:0] data_in;
   logic        coef_wr_en;
   logic [3:0]  coef_addr;
   logic [7:0]  coef_wdata;
   logic [3:0]  cfg_shift;
   logic        cfg_mode, cfg_wr_en, cfg_commit;
   logic        out_valid, out_ready;
   logic [7:0]  mac_out;
   logic        out_sat;

   conv_mac_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .data_in(data_in), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
      .coef_wdata(coef_wdata), .cfg_shift(cfg_shift), .cfg_mode(cfg_mode),
      .cfg_wr_en(cfg_wr_en), .cfg_commit(cfg_commit), .out_valid(out_valid),
      .out_ready(out_ready), .mac_out(mac_out), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int n_pop = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct { int mac; int sat; } res_t;
   res_t exp_q[$];
   int sh_coef[9], act_coef[9];
   int sh_shift, act_shift, sh_mode, act_mode;

   function automatic res_t model(input logic [71:0] win, input int c[9], input int sh, input int md);
      longint sum, r;
      res_t o;
      sum = 0;
      for (int i = 0; i < 9; i++) sum += longint'(win[(8-i)*8 +: 8]) * c[i];
      r = (sh > 0) ? ((sum + (longint'(1) << (sh - 1))) >>> sh) : sum;
      if (md == 1 && r < 0) r = -r;
      if (r < 0)        begin o.mac = 0;   o.sat = 1; end
      else if (r > 255) begin o.mac = 255; o.sat = 1; end
      else              begin o.mac = int'(r); o.sat = 0; end
      return o;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 9; i++) begin
         sh_coef[i]  = (i == 4) ? 1 : 0;
         act_coef[i] = (i == 4) ? 1 : 0;
      end
      sh_shift = 0; act_shift = 0; sh_mode = 0; act_mode = 0;
      exp_q.delete();
   endtask

   // Monitor: inputs are stable at the falling edge, so it sees exactly what the next rising edge will do.
   always @(negedge clk) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         chk("in_ready_rule", in_ready, (!out_valid || out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_out_valid", 1, 0);
            end else begin
               chk("sb_mac_out", mac_out, exp_q[0].mac);
               chk("sb_out_sat", out_sat, exp_q[0].sat);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  n_pop++;
               end
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(data_in, act_coef, act_shift, act_mode));
         if (cfg_commit) begin
            act_coef = sh_coef; act_shift = sh_shift; act_mode = sh_mode;
         end
         if (coef_wr_en && coef_addr < 9) sh_coef[coef_addr] = int'($signed(coef_wdata));
         if (cfg_wr_en) begin sh_shift = int'(cfg_shift); sh_mode = int'(cfg_mode); end
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [71:0] p9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      return {8'(a0), 8'(a1), 8'(a2), 8'(a3), 8'(a4), 8'(a5), 8'(a6), 8'(a7), 8'(a8)};
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      in_valid = 0; coef_wr_en = 0; cfg_wr_en = 0; cfg_commit = 0;
   endtask

   task automatic program_bank(input logic [71:0] c, input int sh, input int md);
      for (int i = 0; i < 9; i++) begin
         coef_wr_en = 1; coef_addr = 4'(i); coef_wdata = c[(8-i)*8 +: 8];
         tick();
      end
      coef_wr_en = 0; cfg_wr_en = 1; cfg_shift = 4'(sh); cfg_mode = md[0];
      tick();
      cfg_wr_en = 0; cfg_commit = 1;
      tick();
      cfg_commit = 0;
   endtask

   // Present a window and return just after the edge that accepts it; in_valid stays high.
   task automatic send(input logic [71:0] w);
      bit ok;
      ok = 0;
      in_valid = 1; data_in = w;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; break; end
      end
      if (!ok) chk("accept_timeout", 0, 1);
      tick();
   endtask

   task automatic wait_out(output int m, output int s);
      bit got;
      got = 0; m = -1; s = -1;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (out_valid) begin got = 1; m = int'(mac_out); s = int'(out_sat); break; end
      end
      if (!got) chk("out_valid_timeout", 0, 1);
   endtask

   typedef struct {
      string       name;
      logic [71:0] coefs;
      logic [71:0] win;
      int          shift;
      int          mode;
      int          exp_mac;
      int          exp_sat;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int m, s, pop0;
      logic [71:0] ident, ones, sobel, nones;
      ident = p9(0,0,0,0,1,0,0,0,0);
      ones  = p9(1,1,1,1,1,1,1,1,1);
      sobel = p9(-1,0,1,-2,0,2,-1,0,1);
      nones = p9(-1,-1,-1,-1,-1,-1,-1,-1,-1);
      vecs[0] = '{"identity",  ident, p9(0,1,2,3,4,5,6,7,8),           0,  0, 4,   0};
      vecs[1] = '{"ones_sh3",  ones,  p9(200,200,200,200,200,200,200,200,200), 3, 0, 225, 0};
      vecs[2] = '{"sobel_abs", sobel, p9(0,100,255,0,100,255,0,100,255), 0, 1, 255, 1};
      vecs[3] = '{"sobel_abs_mirror", sobel, p9(255,100,0,255,100,0,255,100,0), 0, 1, 255, 1};
      vecs[4] = '{"sobel_clip_mirror", sobel, p9(255,100,0,255,100,0,255,100,0), 0, 0, 0, 1};
      vecs[5] = '{"sobel_clip_high", sobel, p9(0,100,255,0,100,255,0,100,255), 0, 0, 255, 1};
      vecs[6] = '{"ones_sh4",  ones,  p9(0,1,2,3,4,5,6,7,8),           4,  0, 2,   0};
      vecs[7] = '{"neg_round", nones, p9(10,10,10,10,10,10,10,10,10),  1,  1, 45,  0};
      vecs[8] = '{"max_exact", ident, p9(0,0,0,0,255,0,0,0,0),         0,  0, 255, 0};
      vecs[9] = '{"ones_sat",  ones,  p9(255,255,255,255,255,255,255,255,255), 3, 0, 255, 1};

      rst_n = 0; out_ready = 0; data_in = '0; coef_addr = '0; coef_wdata = '0;
      cfg_shift = '0; cfg_mode = 0;
      idle_inputs();
      #1;
      chk("reset_in_ready", in_ready, 1);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_mac_out", mac_out, 0);
      chk("reset_out_sat", out_sat, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1;
      out_ready = 1;
      tick();

      // Identity bank after reset and pipeline latency.
      in_valid = 1; data_in = p9(0,1,2,3,4,5,6,7,8);
      @(posedge clk); #1 in_valid = 0;
      @(negedge clk); chk("lat_edge1_valid", out_valid, 0);
      @(negedge clk); chk("lat_edge2_valid", out_valid, 0);
      @(negedge clk); chk("lat_edge3_valid", out_valid, 1);
      chk("lat_mac_out", mac_out, 4);
      chk("lat_out_sat", out_sat, 0);
      tick();

      // Table-driven vectors.
      foreach (vecs[i]) begin
         program_bank(vecs[i].coefs, vecs[i].shift, vecs[i].mode);
         send(vecs[i].win);
         in_valid = 0;
         wait_out(m, s);
         chk({vecs[i].name, "_mac"}, m, vecs[i].exp_mac);
         chk({vecs[i].name, "_sat"}, s, vecs[i].exp_sat);
         tick();
      end

      // Commit on the same edge as window A; window B on the next edge.
      program_bank(ones, 0, 0);
      for (int i = 0; i < 9; i++) begin
         coef_wr_en = 1; coef_addr = 4'(i); coef_wdata = ident[(8-i)*8 +: 8];
         tick();
      end
      coef_wr_en = 0;
      in_valid = 1; data_in = p9(20,20,20,20,20,20,20,20,20); cfg_commit = 1;
      tick();
      cfg_commit = 0; data_in = p9(20,20,20,20,20,20,20,20,20);
      tick();
      in_valid = 0;
      wait_out(m, s); chk("commit_A_old_bank", m, 180);
      wait_out(m, s); chk("commit_B_new_bank", m, 20);
      tick();

      // Write and commit together: commit takes the pre-write value.
      coef_wr_en = 1; coef_addr = 4; coef_wdata = 8'd3; cfg_commit = 1;
      tick();
      coef_wr_en = 0; cfg_commit = 0;
      send(p9(20,20,20,20,20,20,20,20,20)); in_valid = 0;
      wait_out(m, s); chk("wr_commit_same_edge", m, 20);
      tick();
      // Out-of-range address is ignored; committed bank has centre tap 3.
      coef_wr_en = 1; coef_addr = 9; coef_wdata = 8'd7;
      tick();
      coef_wr_en = 0; cfg_commit = 1;
      tick();
      cfg_commit = 0;
      send(p9(0,1,2,3,4,5,6,7,8)); in_valid = 0;
      wait_out(m, s); chk("addr9_ignored", m, 12);
      tick();

      // Ten back-to-back windows with a four-cycle stall mid-stream.
      pop0 = n_pop;
      fork
         begin
            for (int i = 0; i < 10; i++) send({$urandom, $urandom, $urandom});
            in_valid = 0;
         end
         begin
            repeat (5) @(posedge clk);
            #2 out_ready = 0;
            repeat (4) begin
               @(negedge clk);
               chk("stall_in_ready", in_ready, 0);
               chk("stall_out_valid", out_valid, 1);
            end
            @(posedge clk); #2 out_ready = 1;
         end
      join
      repeat (10) tick();
      chk("stream_count", n_pop - pop0, 10);

      // Randomized traffic with random bank updates and back-pressure.
      for (int c = 0; c < 400; c++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         data_in    = {$urandom, $urandom, $urandom};
         coef_wr_en = ($urandom_range(0, 4) == 0);
         coef_addr  = 4'($urandom_range(0, 10));
         coef_wdata = 8'($urandom);
         cfg_wr_en  = ($urandom_range(0, 9) == 0);
         cfg_shift  = 4'($urandom);
         cfg_mode   = 1'($urandom);
         cfg_commit = ($urandom_range(0, 7) == 0);
         out_ready  = ($urandom_range(0, 3) != 0);
         tick();
      end
      idle_inputs(); out_ready = 1;
      repeat (10) tick();
      chk("random_drained", exp_q.size(), 0);

      // Reset with three windows in flight.
      send(p9(9,9,9,9,9,9,9,9,9));
      send(p9(8,8,8,8,8,8,8,8,8));
      send(p9(7,7,7,7,7,7,7,7,7));
      in_valid = 0;
      #2 rst_n = 0;
      #1 chk("async_rst_out_valid", out_valid, 0);
      chk("async_rst_mac_out", mac_out, 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1;
      repeat (4) begin
         @(negedge clk);
         chk("post_rst_no_stale", out_valid, 0);
      end
      tick();
      send(p9(0,1,2,3,4,5,6,7,8)); in_valid = 0;
      wait_out(m, s);
      chk("post_rst_identity", m, 4);
      chk("post_rst_sat", s, 0);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
